// File: rtl/fifo_ctrl_sync_pkg.sv
// Shared types, defaults and width helpers for the
// synchronous FIFO controller.
package fifo_ctrl_sync_pkg;

   localparam int ADDRESS_SIZE_DEFAULT = 4;
   localparam int AEMPTY_DEFAULT       = 2;

   // Pointers carry one extra MSB to tell full from empty
   function automatic int ptr_width(input int addr_size);
      return addr_size + 1;
   endfunction

   function automatic int afull_default(input int addr_size);
      return (1 << addr_size) - 2;
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } status_t;

   typedef struct packed {
      logic overflow;
      logic underflow;
   } err_t;

   localparam status_t STATUS_RST = '{
      full:         1'b0,
      empty:        1'b1,
      almost_full:  1'b0,
      almost_empty: 1'b1
   };

   localparam err_t ERR_RST = '{
      overflow:  1'b0,
      underflow: 1'b0
   };

endpackage

// File: rtl/fifo_ctrl_sync_if.sv
// Producer/consumer + RAM-side bundle of the FIFO
// controller; slave is the controller itself.
interface fifo_ctrl_sync_if #(
   parameter int ADDRESS_SIZE = 4
);
   logic                    w_en;
   logic                    r_en;
   logic                    flush;
   logic                    err_clr;
   logic                    cw_en;
   logic                    cr_en;
   logic [ADDRESS_SIZE-1:0] w_addr;
   logic [ADDRESS_SIZE-1:0] r_addr;
   logic [ADDRESS_SIZE:0]   count;
   logic                    full;
   logic                    empty;
   logic                    almost_full;
   logic                    almost_empty;
   logic                    overflow;
   logic                    underflow;

   modport master (
      output w_en, r_en, flush, err_clr,
      input  cw_en, cr_en, w_addr, r_addr, count,
      input  full, empty, almost_full, almost_empty,
      input  overflow, underflow
   );

   modport slave (
      input  w_en, r_en, flush, err_clr,
      output cw_en, cr_en, w_addr, r_addr, count,
      output full, empty, almost_full, almost_empty,
      output overflow, underflow
   );
endinterface

// File: rtl/fifo_ctrl_sync_d_ff_sync.sv
// Plain register with synchronous active-low reset
// to a per-instance value.
module d_ff_sync #(
   parameter int             SIZE        = 1,
   parameter logic [SIZE-1:0] RESET_VALUE = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [SIZE-1:0] d,
   output logic [SIZE-1:0] q
);

   // Load d every edge; reset value when rst_n low
   always_ff @(posedge clk) begin
      if (!rst_n) q <= RESET_VALUE;
      else        q <= d;
   end

endmodule

// File: rtl/fifo_ctrl_sync.sv
// Synchronous FIFO controller: pointers, occupancy,
// registered status flags and sticky error flags.
module fifo_ctrl_sync
   import fifo_ctrl_sync_pkg::*;
#(
   parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEFAULT,
   parameter int AFULL_LEVEL  = afull_default(ADDRESS_SIZE),
   parameter int AEMPTY_LEVEL = AEMPTY_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   fifo_ctrl_sync_if.slave bus
);

   localparam int DEPTH = 1 << ADDRESS_SIZE;
   localparam int PW    = ptr_width(ADDRESS_SIZE);
   localparam int MSB   = PW - 1;

   localparam logic [PW-1:0] AFULL_L  = PW'(AFULL_LEVEL);
   localparam logic [PW-1:0] AEMPTY_L = PW'(AEMPTY_LEVEL);

   if (ADDRESS_SIZE < 1) begin : g_bad_size
      $error("fifo_ctrl_sync: ADDRESS_SIZE must be >= 1");
   end
   if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
      $error("fifo_ctrl_sync: AFULL_LEVEL out of range");
   end
   if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > DEPTH - 1) begin : g_bad_aempty
      $error("fifo_ctrl_sync: AEMPTY_LEVEL out of range");
   end

   logic [PW-1:0] w_ptr_q;
   logic [PW-1:0] r_ptr_q;
   logic [PW-1:0] count_q;
   status_t       stat_q;
   err_t          err_q;

   logic [PW-1:0] w_ptr_nxt;
   logic [PW-1:0] r_ptr_nxt;
   logic [PW-1:0] count_nxt;
   status_t       stat_nxt;
   err_t          err_nxt;
   logic          cw_en;
   logic          cr_en;

   // Accept decisions, next pointers, flags and errors
   always_comb begin
      cw_en     = bus.w_en & ~stat_q.full & ~bus.flush;
      cr_en     = bus.r_en & ~stat_q.empty & ~bus.flush;
      w_ptr_nxt = w_ptr_q + {{(PW-1){1'b0}}, cw_en};
      r_ptr_nxt = r_ptr_q + {{(PW-1){1'b0}}, cr_en};
      if (bus.flush) begin
         w_ptr_nxt = '0;
         r_ptr_nxt = '0;
      end
      count_nxt = w_ptr_nxt - r_ptr_nxt;

      stat_nxt.full = (w_ptr_nxt[MSB] != r_ptr_nxt[MSB]) &&
                      (w_ptr_nxt[MSB-1:0] == r_ptr_nxt[MSB-1:0]);
      stat_nxt.empty        = (w_ptr_nxt == r_ptr_nxt);
      stat_nxt.almost_full  = (count_nxt >= AFULL_L);
      stat_nxt.almost_empty = (count_nxt <= AEMPTY_L);

      // A fresh error beats a same-cycle clear
      err_nxt.overflow  = (bus.w_en & stat_q.full) |
                          (err_q.overflow & ~bus.err_clr);
      err_nxt.underflow = (bus.r_en & stat_q.empty) |
                          (err_q.underflow & ~bus.err_clr);
   end

   d_ff_sync #(.SIZE(PW), .RESET_VALUE('0)) u_w_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (w_ptr_nxt),
      .q     (w_ptr_q)
   );

   d_ff_sync #(.SIZE(PW), .RESET_VALUE('0)) u_r_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (r_ptr_nxt),
      .q     (r_ptr_q)
   );

   d_ff_sync #(.SIZE(PW), .RESET_VALUE('0)) u_count (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (count_nxt),
      .q     (count_q)
   );

   d_ff_sync #(.SIZE(4), .RESET_VALUE(STATUS_RST)) u_stat (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (stat_nxt),
      .q     (stat_q)
   );

   d_ff_sync #(.SIZE(2), .RESET_VALUE(ERR_RST)) u_err (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (err_nxt),
      .q     (err_q)
   );

   assign bus.cw_en        = cw_en;
   assign bus.cr_en        = cr_en;
   assign bus.w_addr       = w_ptr_q[ADDRESS_SIZE-1:0];
   assign bus.r_addr       = r_ptr_q[ADDRESS_SIZE-1:0];
   assign bus.count        = count_q;
   assign bus.full         = stat_q.full;
   assign bus.empty        = stat_q.empty;
   assign bus.almost_full  = stat_q.almost_full;
   assign bus.almost_empty = stat_q.almost_empty;
   assign bus.overflow     = err_q.overflow;
   assign bus.underflow    = err_q.underflow;

endmodule

// File: tb/tb_fifo_ctrl_sync.sv
// Directed, table-driven bench for fifo_ctrl_sync
// at DEPTH=4, AFULL=3, AEMPTY=1.
module tb_fifo_ctrl_sync;

   typedef struct {
      bit       rst_n, w, r, fl, ec;
      bit       cw, cr;
      bit [1:0] wa, ra;
      bit [2:0] cnt;
      bit       f, e, af, ae, ov, un;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   vec_t va[$];
   vec_t vb[$];

   fifo_ctrl_sync_if #(.ADDRESS_SIZE(2)) bus();

   fifo_ctrl_sync #(
      .ADDRESS_SIZE (2),
      .AFULL_LEVEL  (3),
      .AEMPTY_LEVEL (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(
      input int rs, w, r, fl, ec, cw, cr, wa, ra, cnt,
      input int f, e, af, ae, ov, un);
      vec_t v;
      v.rst_n = rs[0]; v.w = w[0]; v.r = r[0];
      v.fl = fl[0]; v.ec = ec[0];
      v.cw = cw[0]; v.cr = cr[0];
      v.wa = 2'(wa); v.ra = 2'(ra); v.cnt = 3'(cnt);
      v.f = f[0]; v.e = e[0]; v.af = af[0];
      v.ae = ae[0]; v.ov = ov[0]; v.un = un[0];
      return v;
   endfunction

   // Drive after negedge, compare before next posedge
   task automatic apply(input vec_t v, input string nm);
      logic [14:0] act, exp;
      @(negedge clk);
      rst_n       = v.rst_n;
      bus.w_en    = v.w;
      bus.r_en    = v.r;
      bus.flush   = v.fl;
      bus.err_clr = v.ec;
      #1;
      act = {bus.cw_en, bus.cr_en, bus.w_addr, bus.r_addr,
             bus.count, bus.full, bus.empty, bus.almost_full,
             bus.almost_empty, bus.overflow, bus.underflow};
      exp = {v.cw, v.cr, v.wa, v.ra, v.cnt, v.f, v.e,
             v.af, v.ae, v.ov, v.un};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got cw,cr,wa,ra,cnt,f,e,af,ae,ov,un=%b want %b",
                  nm, act, exp);
      end
   endtask

   initial begin
      // rs w r fl ec | cw cr wa ra cnt | f e af ae ov un
      va.push_back(mk(1,0,0,0,0, 0,0,0,0,0, 0,1,0,1,0,0));
      va.push_back(mk(1,1,0,0,0, 1,0,0,0,0, 0,1,0,1,0,0));
      va.push_back(mk(1,1,0,0,0, 1,0,1,0,1, 0,0,0,1,0,0));
      va.push_back(mk(1,1,0,0,0, 1,0,2,0,2, 0,0,0,0,0,0));
      va.push_back(mk(1,1,0,0,0, 1,0,3,0,3, 0,0,1,0,0,0));
      va.push_back(mk(1,1,0,0,0, 0,0,0,0,4, 1,0,1,0,0,0));
      va.push_back(mk(1,0,0,0,0, 0,0,0,0,4, 1,0,1,0,1,0));
      va.push_back(mk(1,1,0,0,1, 0,0,0,0,4, 1,0,1,0,1,0));
      va.push_back(mk(1,0,0,0,1, 0,0,0,0,4, 1,0,1,0,1,0));
      va.push_back(mk(1,0,0,0,0, 0,0,0,0,4, 1,0,1,0,0,0));
      va.push_back(mk(1,1,1,0,0, 0,1,0,0,4, 1,0,1,0,0,0));
      va.push_back(mk(1,0,0,0,0, 0,0,0,1,3, 0,0,1,0,1,0));
      va.push_back(mk(1,0,1,0,0, 0,1,0,1,3, 0,0,1,0,1,0));
      va.push_back(mk(1,0,1,0,0, 0,1,0,2,2, 0,0,0,0,1,0));
      va.push_back(mk(1,0,1,0,0, 0,1,0,3,1, 0,0,0,1,1,0));
      va.push_back(mk(1,1,1,0,0, 1,0,0,0,0, 0,1,0,1,1,0));
      va.push_back(mk(1,0,0,0,0, 0,0,1,0,1, 0,0,0,1,1,1));
      va.push_back(mk(1,0,0,0,1, 0,0,1,0,1, 0,0,0,1,1,1));
      va.push_back(mk(1,1,0,0,0, 1,0,1,0,1, 0,0,0,1,0,0));
      va.push_back(mk(1,0,0,0,0, 0,0,2,0,2, 0,0,0,0,0,0));

      vb.push_back(mk(1,1,0,0,0, 1,0,2,0,2, 0,0,0,0,0,0));
      vb.push_back(mk(1,1,0,1,0, 0,0,3,0,3, 0,0,1,0,0,0));
      vb.push_back(mk(1,0,0,0,0, 0,0,0,0,0, 0,1,0,1,0,0));
      vb.push_back(mk(1,0,1,0,0, 0,0,0,0,0, 0,1,0,1,0,0));
      vb.push_back(mk(1,1,0,0,0, 1,0,0,0,0, 0,1,0,1,0,1));
      vb.push_back(mk(1,1,0,0,0, 1,0,1,0,1, 0,0,0,1,0,1));
      vb.push_back(mk(1,1,0,0,0, 1,0,2,0,2, 0,0,0,0,0,1));
      vb.push_back(mk(1,1,1,1,0, 0,0,3,0,3, 0,0,1,0,0,1));
      vb.push_back(mk(1,0,0,0,0, 0,0,0,0,0, 0,1,0,1,0,1));
      vb.push_back(mk(1,1,0,0,0, 1,0,0,0,0, 0,1,0,1,0,1));
      vb.push_back(mk(1,1,0,0,0, 1,0,1,0,1, 0,0,0,1,0,1));
      vb.push_back(mk(0,1,1,0,0, 1,1,2,0,2, 0,0,0,0,0,1));
      vb.push_back(mk(1,0,0,0,0, 0,0,0,0,0, 0,1,0,1,0,0));
      vb.push_back(mk(1,1,0,0,0, 1,0,0,0,0, 0,1,0,1,0,0));
      vb.push_back(mk(1,1,0,0,0, 1,0,1,0,1, 0,0,0,1,0,0));
      vb.push_back(mk(1,0,0,0,0, 0,0,2,0,2, 0,0,0,0,0,0));

      rst_n       = 1'b0;
      bus.w_en    = 1'b0;
      bus.r_en    = 1'b0;
      bus.flush   = 1'b0;
      bus.err_clr = 1'b0;
      repeat (2) @(posedge clk);

      foreach (va[i]) apply(va[i], $sformatf("fill_err_row%0d", i));

      // Steady R/W at count 2: addresses wrap, flags hold
      for (int k = 0; k < 20; k++)
         apply(mk(1,1,1,0,0, 1,1,(2+k)%4,k%4,2, 0,0,0,0,0,0),
               $sformatf("stream_cyc%0d", k));

      foreach (vb[i]) apply(vb[i], $sformatf("flush_rst_row%0d", i));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
